controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameters: none; state encoding and opcode values are fixed by this document.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-004 op  input  6  instruction opcode field (ir[31:26]), stable from DECODE onward.
REQ-005 zero  input  1  ALU zero flag from the datapath ALU, combinational.
REQ-006 memread  output  1  memory read strobe.
REQ-007 memwrite  output  1  memory write strobe.
REQ-008 irwrite  output  4  one-hot byte-lane write enable for the instruction register (bit0 = byte 0).
REQ-009 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 pcen  output  1  PC register enable.
REQ-011 pcsource  output  2  next-PC mux: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-012 alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-013 alusrcb  output  2  ALU B select: 00 = register B, 01 = constant 1, 10 = immediate, 11 = immediate branch offset.
REQ-014 aluop  output  2  to the ALU decoder: 00 = add, 01 = subtract, 10 = use funct field.
REQ-015 regwrite  output  1  register-file write enable.
REQ-016 regdst  output  1  destination register select: 0 = rt, 1 = rd.
REQ-017 memtoreg  output  1  write-back select: 0 = ALUOut, 1 = memory data.

Function
REQ-018 The controller SHALL be a Moore FSM with 4-bit state register; the only Mealy term is pcen.
REQ-019 States and encodings SHALL be: FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14.
REQ-020 Opcodes SHALL be: LB=100000, SB=101000, RTYPE=000000, BEQ=000100, J=000010, ADDI=001000.
REQ-021 Transitions SHALL be: FETCH1->FETCH2->FETCH3->FETCH4->DECODE, unconditionally.
REQ-022 From DECODE: LB or SB->MEMADR; RTYPE->RTYPEEX; BEQ->BEQEX; J->JEX; ADDI->ADDIEX; any other op->FETCH1.
REQ-023 From MEMADR: LB->LBRD; SB->SBWR; any other op->FETCH1.
REQ-024 Remaining transitions: LBRD->LBWR; RTYPEEX->RTYPEWR; ADDIEX->ADDIWR.
REQ-025 LBWR, SBWR, RTYPEWR, BEQEX, JEX and ADDIWR SHALL each go to FETCH1; unused encoding 15 SHALL go to FETCH1.
REQ-026 FETCHn (n=1..4) SHALL drive memread=1, irwrite=1<<(n-1), alusrcb=01, pcsource=00 and an internal pcwrite=1.
REQ-027 DECODE SHALL drive alusrcb=11; MEMADR and ADDIEX SHALL drive alusrca=1 and alusrcb=10.
REQ-028 LBRD SHALL drive memread=1 and iord=1; LBWR SHALL drive regwrite=1 and memtoreg=1; SBWR SHALL drive memwrite=1 and iord=1.
REQ-029 RTYPEEX SHALL drive alusrca=1 and aluop=10; RTYPEWR SHALL drive regwrite=1 and regdst=1; ADDIWR SHALL drive regwrite=1.
REQ-030 BEQEX SHALL drive alusrca=1, aluop=01, pcsource=01 and an internal branch=1; JEX SHALL drive pcwrite=1 and pcsource=10.
REQ-031 Every output not listed for a state SHALL be 0.
REQ-032 pcen SHALL equal pcwrite OR (branch AND zero), combinationally; zero SHALL be ignored outside BEQEX.
REQ-033 Instruction latency, counted from entering FETCH1 to re-entering FETCH1, SHALL be: LB 8 cycles; SB 7; RTYPE 7; ADDI 7; BEQ 6; J 6; undefined opcode 5.

Reset
REQ-034 When reset=0, the state SHALL be forced to FETCH1 asynchronously and all outputs SHALL be forced to 0, including pcen.
REQ-035 On the first rising clk edge after reset goes to 1, the state SHALL be FETCH1 and the FETCH1 outputs SHALL be valid.
REQ-036 Reset asserted mid-instruction SHALL abandon the instruction with no further regwrite or memwrite pulse.

Verification
REQ-037 Release reset, op=000000 -> irwrite 0001,0010,0100,1000 on cycles 1-4; pcen=1 in each fetch cycle; regwrite=1 and regdst=1 only on cycle 7; back in FETCH1 on cycle 8.
REQ-038 op=100000 (LB) -> LBRD on cycle 7 with memread=1 and iord=1; cycle 8 has regwrite=1 and memtoreg=1; memwrite stays 0 throughout.
REQ-039 op=000100 (BEQ) with zero=1 in BEQEX -> pcen=1 and pcsource=01 on cycle 6; repeating with zero=0 -> pcen=0 on cycle 6.
REQ-040 op=000010 (J) -> pcen=1 and pcsource=10 on cycle 6; op=111111 -> return to FETCH1 after DECODE (5-cycle loop) with no regwrite or memwrite.
REQ-041 Assert reset=0 asynchronously in SBWR mid-cycle -> memwrite drops to 0 immediately, before the next clk edge; after release, execution restarts in FETCH1.

Source files
------------

// File: rtl/controller.sv
// Multicycle processor controller: a Moore FSM that fetches a 32-bit
// instruction byte by byte, decodes the opcode and sequences the datapath
// through the memory, R-type, branch, jump and add-immediate paths.
// pcen is the only output that also depends on an input (zero).
module controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic [3:0] irwrite,
    output logic       iord,
    output logic       pcen,
    output logic [1:0] pcsource,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg
);

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13,
        ADDIWR  = 4'd14
    } state_t;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q, state_d;
    logic   pcwrite, branch;

    // State register, forced to FETCH1 while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH1;
        else        state_q <= state_d;
    end

    // Next-state selection from the current state and opcode.
    always_comb begin
        state_d = FETCH1;
        unique case (state_q)
            FETCH1:  state_d = FETCH2;
            FETCH2:  state_d = FETCH3;
            FETCH3:  state_d = FETCH4;
            FETCH4:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = FETCH1;
                endcase
            end
            MEMADR: begin
                case (op)
                    OP_LB:   state_d = LBRD;
                    OP_SB:   state_d = SBWR;
                    default: state_d = FETCH1;
                endcase
            end
            LBRD:    state_d = LBWR;
            RTYPEEX: state_d = RTYPEWR;
            ADDIEX:  state_d = ADDIWR;
            default: state_d = FETCH1;
        endcase
    end

    // Per-state datapath controls; everything is held at 0 while reset is low
    // so an instruction in flight cannot emit a write strobe.
    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = '0;
        iord     = 1'b0;
        pcsource = '0;
        alusrca  = 1'b0;
        alusrcb  = '0;
        aluop    = '0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        if (reset) begin
            case (state_q)
                FETCH1, FETCH2, FETCH3, FETCH4: begin
                    memread = 1'b1;
                    irwrite = 4'b0001 << state_q[1:0];
                    alusrcb = 2'b01;
                    pcwrite = 1'b1;
                end
                DECODE:  alusrcb = 2'b11;
                MEMADR, ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                LBRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                LBWR: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                SBWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                RTYPEWR: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                BEQEX: begin
                    alusrca  = 1'b1;
                    aluop    = 2'b01;
                    pcsource = 2'b01;
                    branch   = 1'b1;
                end
                JEX: begin
                    pcwrite  = 1'b1;
                    pcsource = 2'b10;
                end
                ADDIWR:  regwrite = 1'b1;
                default: ;
            endcase
        end
        pcen = pcwrite | (branch & zero);
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for the multicycle controller. A cycle-indexed
// reference model gives the expected control vector for each cycle of an
// instruction; directed steps cover reset and mid-instruction reset.
module tb_controller;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       memread, memwrite, iord, pcen, alusrca, regwrite, regdst, memtoreg;
    logic [3:0] irwrite;
    logic [1:0] pcsource, alusrcb, aluop;
    logic [17:0] dut_vec;

    int checks = 0;
    int errors = 0;

    controller dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .zero     (zero),
        .memread  (memread),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .iord     (iord),
        .pcen     (pcen),
        .pcsource (pcsource),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .aluop    (aluop),
        .regwrite (regwrite),
        .regdst   (regdst),
        .memtoreg (memtoreg)
    );

    always #5 clk = ~clk;

    assign dut_vec = {memread, memwrite, irwrite, iord, pcen, pcsource,
                      alusrca, alusrcb, aluop, regwrite, regdst, memtoreg};

    // Cycles from entering FETCH1 to re-entering FETCH1.
    function automatic int instr_len(input logic [5:0] o);
        case (o)
            OP_LB:                   return 8;
            OP_SB, OP_RTYPE, OP_ADDI: return 7;
            OP_BEQ, OP_J:            return 6;
            default:                 return 5;
        endcase
    endfunction

    // Expected control vector for cycle k (0-based) of instruction o.
    function automatic logic [17:0] model(input logic [5:0] o, input int k, input logic z);
        logic mr, mw, io, pcw, br, asa, rw, rd, m2r;
        logic [3:0] ir;
        logic [1:0] ps, asb, aop;
        int j;
        mr = 0; mw = 0; io = 0; pcw = 0; br = 0; asa = 0; rw = 0; rd = 0; m2r = 0;
        ir = '0; ps = '0; asb = '0; aop = '0;
        j = k - 5;
        if (k < 4) begin
            mr = 1; ir = 4'(1 << k); asb = 2'b01; pcw = 1;
        end else if (k == 4) begin
            asb = 2'b11;
        end else begin
            case (o)
                OP_LB: begin
                    if (j == 0) begin asa = 1; asb = 2'b10; end
                    if (j == 1) begin mr = 1; io = 1; end
                    if (j == 2) begin rw = 1; m2r = 1; end
                end
                OP_SB: begin
                    if (j == 0) begin asa = 1; asb = 2'b10; end
                    if (j == 1) begin mw = 1; io = 1; end
                end
                OP_RTYPE: begin
                    if (j == 0) begin asa = 1; aop = 2'b10; end
                    if (j == 1) begin rw = 1; rd = 1; end
                end
                OP_ADDI: begin
                    if (j == 0) begin asa = 1; asb = 2'b10; end
                    if (j == 1) rw = 1;
                end
                OP_BEQ: begin asa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
                OP_J:   begin pcw = 1; ps = 2'b10; end
                default: ;
            endcase
        end
        return {mr, mw, ir, io, pcw | (br & z), ps, asa, asb, aop, rw, rd, m2r};
    endfunction

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Runs n cycles of instruction o; zm: 0/1 = fixed zero, 2 = random zero.
    task automatic run_instr(input logic [5:0] o, input int n, input int zm);
        op = o;
        for (int k = 0; k < n; k++) begin
            zero = (zm == 2) ? 1'($urandom_range(0, 1)) : 1'(zm);
            #1;
            chk($sformatf("op%b_c%0d", o, k + 1), dut_vec, model(o, k, zero));
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] rop;
        reset = 1'b0;
        op    = OP_RTYPE;
        zero  = 1'b1;

        // Outputs held low during reset, across clock edges.
        @(negedge clk);
        #1 chk("reset_hold", dut_vec, '0);
        @(negedge clk);
        #1 chk("reset_hold2", dut_vec, '0);
        reset = 1'b1;

        // Directed instructions.
        run_instr(OP_RTYPE, instr_len(OP_RTYPE), 2);
        run_instr(OP_LB,    instr_len(OP_LB),    2);
        run_instr(OP_BEQ,   instr_len(OP_BEQ),   1);
        run_instr(OP_BEQ,   instr_len(OP_BEQ),   0);
        run_instr(OP_J,     instr_len(OP_J),     0);
        run_instr(6'b111111, instr_len(6'b111111), 1);
        run_instr(OP_SB,    instr_len(OP_SB),    2);
        run_instr(OP_ADDI,  instr_len(OP_ADDI),  2);

        // Mid-instruction reset in SBWR.
        run_instr(OP_SB, 6, 0);
        zero = 1'b0;
        #1 chk("sbwr_before_reset", dut_vec, model(OP_SB, 6, 1'b0));
        #1 reset = 1'b0;
        #1 chk("sbwr_async_reset", dut_vec, '0);
        @(posedge clk);
        @(negedge clk);
        #1 chk("reset_after_edge", dut_vec, '0);
        reset = 1'b1;
        run_instr(OP_LB, instr_len(OP_LB), 2);

        // Randomized instruction stream.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 6))
                0: rop = OP_LB;
                1: rop = OP_SB;
                2: rop = OP_RTYPE;
                3: rop = OP_BEQ;
                4: rop = OP_J;
                5: rop = OP_ADDI;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            run_instr(rop, instr_len(rop), 2);
        end

        zero = 1'b0;
        #1 chk("final_fetch1", dut_vec, model(op, 0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
